updn_counter_multi: RTL and testbench
=====================================

UPDN_COUNTER_MULTI -- requirements
Module: updn_counter_multi

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits per channel (legal 2..32).
REQ-002 Parameter CHANNELS, default 4, number of independent counter channels (legal 1..16).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  CHANNELS  per-channel count enable.
REQ-006 Port up  input  CHANNELS  per-channel count-up request.
REQ-007 Port down  input  CHANNELS  per-channel count-down request.
REQ-008 Port load  input  CHANNELS  per-channel synchronous load strobe.
REQ-009 Port load_val  input  CHANNELS*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
REQ-010 Port max_val  input  WIDTH  shared terminal value; count range 0..max_val.
REQ-011 Port sat_mode  input  1  0 = wrap at limits, 1 = saturate at limits; shared by all channels.
REQ-012 Port count  output  CHANNELS*WIDTH  registered count values, same packing as load_val.
REQ-013 Port tc_up  output  CHANNELS  one-cycle registered pulse on an up-limit event.
REQ-014 Port tc_dn  output  CHANNELS  one-cycle registered pulse on a down-limit event.

Function
REQ-015 Per-channel priority each cycle: rst > load > (en and exactly one of up/down) > hold.
REQ-016 load: count <= min(load_val, max_val); no tc pulse; en/up/down ignored that cycle.
REQ-017 en=0, or up=down=0, or up=down=1: count holds, no tc pulse.
REQ-018 Up, count < max_val: count <= count+1.
REQ-019 Up, count >= max_val, sat_mode=0: count <= 0, tc_up pulses next cycle.
REQ-020 Up, count >= max_val, sat_mode=1: count <= max_val, tc_up pulses next cycle.
REQ-021 Down, count > 0 and count <= max_val: count <= count-1.
REQ-022 Down, count > max_val (max_val lowered at runtime): count <= max_val, no tc pulse.
REQ-023 Down, count = 0, sat_mode=0: count <= max_val, tc_dn pulses next cycle.
REQ-024 Down, count = 0, sat_mode=1: count holds 0, tc_dn pulses next cycle.
REQ-025 max_val = 0: every enabled up or down step leaves count at 0 and pulses the matching tc.
REQ-026 tc_up/tc_dn are registered alongside count (same edge), high for exactly one cycle per event; consecutive events give consecutive pulses.
REQ-027 Channels are fully independent; no arithmetic carries across channel boundaries; all arithmetic is WIDTH-bit, unsigned.
REQ-028 Latency: count and tc outputs reflect inputs sampled on the previous rising edge (1 cycle).

Reset
REQ-029 rst=1 at a rising edge: all count fields <= 0, tc_up <= 0, tc_dn <= 0, overrides load/en mid-operation.
REQ-030 First edge after rst deasserts processes inputs normally; no pulse generated by reset itself.

Configuration
REQ-031 Macro UPDN_COUNTER_STICKY_OVF_EN defined: adds input ovf_clr (CHANNELS) and output ovf (CHANNELS); ovf[i] sets on any tc_up or tc_dn event of channel i, holds until ovf_clr[i]=1 or rst; set wins over simultaneous clear.
REQ-032 Macro not defined: ports ovf and ovf_clr absent, no sticky state synthesised; all other behaviour identical.

Structure
REQ-033 Package updn_counter_pkg holds the mode enum (WRAP=0, SAT=1) and the default WIDTH/CHANNELS constants.
REQ-034 Sub-module updn_counter_chan implements one channel (count, tc, optional ovf); top generates CHANNELS instances and packs/unpacks buses.

Verification
REQ-035 WIDTH=8, max_val=255, sat_mode=0, ch0 up for 256 cycles from 0 -> count 0, tc_up pulse exactly once on the wrap edge.
REQ-036 max_val=9, sat_mode=1, ch1 load 7 then up 5 cycles -> 8,9,9,9,9; tc_up high on 3 consecutive cycles.
REQ-037 max_val=9, sat_mode=0, ch2 at 0 down once -> count 9, tc_dn one pulse; up=down=1 next cycle -> holds 9.
REQ-038 ch3 load_val=200 with max_val=50 -> count 50; then max_val=20, down -> count 20, no tc_dn.
REQ-039 ch0 counting up at 5 with load asserted and rst asserted same edge -> count 0, no pulses; next edge load_val=3 -> count 3.
REQ-040 With UPDN_COUNTER_STICKY_OVF_EN: wrap event on ch1 -> ovf[1]=1 held 10 cycles; ovf_clr[1] with simultaneous wrap -> ovf[1] stays 1; clr alone -> 0.

Source files
------------

// File: rtl/updn_counter_pkg.sv
// rtl/updn_counter_pkg.sv - shared types and defaults for the multi-channel up/down counter
// Purpose : mode enum and default geometry used by updn_counter_multi and updn_counter_chan.
// Contents: mode_e (WRAP=0, SAT=1), DEF_WIDTH, DEF_CHANNELS.
package updn_counter_pkg;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } mode_e;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/updn_counter_chan.sv
// rtl/updn_counter_chan.sv - one channel of the multi-channel up/down counter
// Purpose : bounded up/down counter (range 0..max_val) with wrap/saturate limits,
//           registered terminal-count pulses and optional sticky overflow flag.
// Ports   : clk, rst (sync, active-high)
//           en, up, down, load       - per-channel controls
//           load_val[WIDTH], max_val[WIDTH], sat_mode
//           count[WIDTH], tc_up, tc_dn - registered outputs
//           ovf_clr / ovf             - only when UPDN_COUNTER_STICKY_OVF_EN is defined
// Macro   : UPDN_COUNTER_STICKY_OVF_EN
module updn_counter_chan
   import updn_counter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] max_val,
   input  logic             sat_mode,
`ifdef UPDN_COUNTER_STICKY_OVF_EN
   input  logic             ovf_clr,
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc_up,
   output logic             tc_dn
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0] r_count;
   logic             r_tc_up;
   logic             r_tc_dn;

   logic [WIDTH-1:0] w_next;
   logic             w_ev_up;
   logic             w_ev_dn;
   mode_e            w_mode;

   assign w_mode = mode_e'(sat_mode);

   always_comb begin
      w_next  = r_count;
      w_ev_up = 1'b0;
      w_ev_dn = 1'b0;
      if (load) begin
         w_next = (load_val > max_val) ? max_val : load_val;
      end else if (en && (up ^ down)) begin
         if (up) begin
            // ">=" so a count stranded above a lowered max_val still hits the limit
            if (r_count >= max_val) begin
               w_next  = (w_mode == SAT) ? max_val : ZERO;
               w_ev_up = 1'b1;
            end else begin
               w_next = r_count + ONE;
            end
         end else begin
            if (r_count > max_val) begin
               // pull back into range after max_val was lowered; not a limit event
               w_next = max_val;
            end else if (r_count == ZERO) begin
               w_next  = (w_mode == SAT) ? ZERO : max_val;
               w_ev_dn = 1'b1;
            end else begin
               w_next = r_count - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_tc_up <= 1'b0;
         r_tc_dn <= 1'b0;
      end else begin
         r_count <= w_next;
         r_tc_up <= w_ev_up;
         r_tc_dn <= w_ev_dn;
      end
   end

`ifdef UPDN_COUNTER_STICKY_OVF_EN
   logic r_ovf;

   // set has priority over clear so an event coinciding with clear is not lost
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_ev_up || w_ev_dn) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign ovf = r_ovf;
`endif

   assign count = r_count;
   assign tc_up = r_tc_up;
   assign tc_dn = r_tc_dn;

endmodule

// File: rtl/updn_counter_multi.sv
// rtl/updn_counter_multi.sv - CHANNELS independent bounded up/down counters
// Purpose : instantiates one updn_counter_chan per channel and packs/unpacks the buses.
// Ports   : clk, rst (sync, active-high)
//           en/up/down/load[CHANNELS], load_val[CHANNELS*WIDTH] (ch i at [i*WIDTH +: WIDTH])
//           max_val[WIDTH], sat_mode (shared)
//           count[CHANNELS*WIDTH], tc_up[CHANNELS], tc_dn[CHANNELS]
//           ovf_clr/ovf[CHANNELS] - only when UPDN_COUNTER_STICKY_OVF_EN is defined
// Macro   : UPDN_COUNTER_STICKY_OVF_EN
module updn_counter_multi
   import updn_counter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       up,
   input  logic [CHANNELS-1:0]       down,
   input  logic [CHANNELS-1:0]       load,
   input  logic [CHANNELS*WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0]          max_val,
   input  logic                      sat_mode,
`ifdef UPDN_COUNTER_STICKY_OVF_EN
   input  logic [CHANNELS-1:0]       ovf_clr,
   output logic [CHANNELS-1:0]       ovf,
`endif
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       tc_up,
   output logic [CHANNELS-1:0]       tc_dn
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      updn_counter_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en[g]),
         .up       (up[g]),
         .down     (down[g]),
         .load     (load[g]),
         .load_val (load_val[g*WIDTH +: WIDTH]),
         .max_val  (max_val),
         .sat_mode (sat_mode),
`ifdef UPDN_COUNTER_STICKY_OVF_EN
         .ovf_clr  (ovf_clr[g]),
         .ovf      (ovf[g]),
`endif
         .count    (count[g*WIDTH +: WIDTH]),
         .tc_up    (tc_up[g]),
         .tc_dn    (tc_dn[g])
      );
   end

endmodule

// File: tb/tb_updn_counter_multi.sv
// tb/tb_updn_counter_multi.sv - self-checking bench for updn_counter_multi
module tb_updn_counter_multi;

   localparam int W  = 8;
   localparam int CH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [CH-1:0]     en, up, down, load;
   logic [CH*W-1:0]   load_val;
   logic [W-1:0]      max_val;
   logic              sat_mode;
   logic [CH*W-1:0]   count;
   logic [CH-1:0]     tc_up, tc_dn;
`ifdef UPDN_COUNTER_STICKY_OVF_EN
   logic [CH-1:0]     ovf_clr, ovf;
`endif

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   int m_count [CH];
   bit m_tcu   [CH];
   bit m_tcd   [CH];
   bit m_ovf   [CH];

   always #5 clk = ~clk;

   updn_counter_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .down     (down),
      .load     (load),
      .load_val (load_val),
      .max_val  (max_val),
      .sat_mode (sat_mode),
`ifdef UPDN_COUNTER_STICKY_OVF_EN
      .ovf_clr  (ovf_clr),
      .ovf      (ovf),
`endif
      .count    (count),
      .tc_up    (tc_up),
      .tc_dn    (tc_dn)
   );

   // Behavioural rule set: returns {tc_up, tc_dn, next_count[31:0]}
   function automatic logic [33:0] model_next(input int c, input int mx, input bit sat,
                                              input bit e, input bit u, input bit d,
                                              input bit ld, input int lv);
      int n;
      bit pu, pd;
      n = c; pu = 0; pd = 0;
      if (ld) n = (lv < mx) ? lv : mx;
      else if (e && u && !d) begin
         if (c < mx) n = c + 1;
         else begin n = sat ? mx : 0; pu = 1; end
      end else if (e && d && !u) begin
         if (c > mx) n = mx;
         else if (c > 0) n = c - 1;
         else begin n = sat ? 0 : mx; pd = 1; end
      end
      return {pu, pd, n[31:0]};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < CH; i++) begin
         logic [33:0] r;
         r = model_next(m_count[i], int'(max_val), sat_mode, en[i], up[i], down[i],
                        load[i], int'(load_val[i*W +: W]));
         if (rst) begin
            m_count[i] <= 0; m_tcu[i] <= 0; m_tcd[i] <= 0; m_ovf[i] <= 0;
         end else begin
            m_count[i] <= int'(r[31:0]);
            m_tcu[i]   <= r[33];
            m_tcd[i]   <= r[32];
`ifdef UPDN_COUNTER_STICKY_OVF_EN
            if (r[33] || r[32]) m_ovf[i] <= 1'b1;
            else if (ovf_clr[i]) m_ovf[i] <= 1'b0;
`endif
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < CH; i++) begin
            chk($sformatf("model count[%0d]", i), 32'(count[i*W +: W]), 32'(m_count[i]));
            chk($sformatf("model tc_up[%0d]", i), 32'(tc_up[i]), 32'(m_tcu[i]));
            chk($sformatf("model tc_dn[%0d]", i), 32'(tc_dn[i]), 32'(m_tcd[i]));
`ifdef UPDN_COUNTER_STICKY_OVF_EN
            chk($sformatf("model ovf[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      en = '0; up = '0; down = '0; load = '0;
`ifdef UPDN_COUNTER_STICKY_OVF_EN
      ovf_clr = '0;
`endif
   endtask

   function automatic int cnt(input int ch);
      return int'(count[ch*W +: W]);
   endfunction

   initial begin
      int pulses;
      int exp36 [5];
      int tc36  [5];
      exp36[0] = 8; exp36[1] = 9; exp36[2] = 9; exp36[3] = 9; exp36[4] = 9;
      tc36[0]  = 0; tc36[1]  = 0; tc36[2]  = 1; tc36[3]  = 1; tc36[4]  = 1;

      rst = 1'b1; idle(); load_val = '0; max_val = 8'd255; sat_mode = 1'b0;
      tick();
      check_en = 1'b1;
      tick();
      for (int i = 0; i < CH; i++) begin
         chk($sformatf("reset count[%0d]", i), 32'(cnt(i)), 0);
         chk($sformatf("reset tc[%0d]", i), 32'({tc_up[i], tc_dn[i]}), 0);
      end

      // full-range wrap on ch0
      rst = 1'b0; en[0] = 1; up[0] = 1; pulses = 0;
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (tc_up[0]) pulses++;
         if (k == 255) chk("ch0 at 255", 32'(cnt(0)), 255);
      end
      chk("ch0 wrap to 0", 32'(cnt(0)), 0);
      chk("ch0 single tc_up", 32'(pulses), 1);
      idle();

      // saturate on ch1
      max_val = 8'd9; sat_mode = 1'b1;
      load[1] = 1; load_val[1*W +: W] = 8'd7;
      tick();
      chk("ch1 load 7", 32'(cnt(1)), 7);
      load[1] = 0; en[1] = 1; up[1] = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("ch1 sat step%0d", k), 32'(cnt(1)), 32'(exp36[k]));
         chk($sformatf("ch1 tc_up step%0d", k), 32'(tc_up[1]), 32'(tc36[k]));
      end
      idle();

      // wrap down on ch2, then up=down=1 holds
      sat_mode = 1'b0;
      en[2] = 1; down[2] = 1;
      tick();
      chk("ch2 down wrap", 32'(cnt(2)), 9);
      chk("ch2 tc_dn", 32'(tc_dn[2]), 1);
      up[2] = 1;
      tick();
      chk("ch2 both hold", 32'(cnt(2)), 9);
      chk("ch2 tc_dn cleared", 32'(tc_dn[2]), 0);
      idle();

      // load clamp and lowered max_val on ch3
      max_val = 8'd50; load[3] = 1; load_val[3*W +: W] = 8'd200;
      tick();
      chk("ch3 load clamp", 32'(cnt(3)), 50);
      load[3] = 0; max_val = 8'd20; en[3] = 1; down[3] = 1;
      tick();
      chk("ch3 pulled to max", 32'(cnt(3)), 20);
      chk("ch3 no tc_dn", 32'(tc_dn[3]), 0);
      idle();

      // reset beats load/en mid-operation
      load[0] = 1; load_val[0*W +: W] = 8'd5;
      tick();
      chk("ch0 load 5", 32'(cnt(0)), 5);
      en[0] = 1; up[0] = 1; load_val[0*W +: W] = 8'd11; rst = 1'b1;
      tick();
      chk("rst overrides ch0", 32'(cnt(0)), 0);
      chk("rst no pulses", 32'({tc_up, tc_dn}), 0);
      chk("rst clears ch3", 32'(cnt(3)), 0);
      rst = 1'b0; load_val[0*W +: W] = 8'd3;
      tick();
      chk("ch0 load after rst", 32'(cnt(0)), 3);
      idle();

      // max_val = 0
      max_val = 8'd0; load[0] = 1; load_val[0*W +: W] = 8'd0;
      tick();
      load[0] = 0; en[0] = 1; up[0] = 1;
      tick();
      chk("max0 up count", 32'(cnt(0)), 0);
      chk("max0 tc_up", 32'(tc_up[0]), 1);
      up[0] = 0; down[0] = 1;
      tick();
      chk("max0 down count", 32'(cnt(0)), 0);
      chk("max0 tc_dn", 32'(tc_dn[0]), 1);
      idle();

`ifdef UPDN_COUNTER_STICKY_OVF_EN
      max_val = 8'd9; sat_mode = 1'b0;
      load[1] = 1; load_val[1*W +: W] = 8'd9;
      tick();
      load[1] = 0; en[1] = 1; up[1] = 1;
      tick();
      chk("ovf set on wrap", 32'(ovf[1]), 1);
      idle();
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("ovf held", 32'(ovf[1]), 1);
      end
      load[1] = 1;
      tick();
      load[1] = 0; en[1] = 1; up[1] = 1; ovf_clr[1] = 1;
      tick();
      chk("ovf set beats clr", 32'(ovf[1]), 1);
      idle(); ovf_clr[1] = 1;
      tick();
      chk("ovf cleared", 32'(ovf[1]), 0);
      idle();
`endif

      // mixed traffic across all channels, checked by the model every cycle
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 3))
            0: max_val = 8'd0;
            1: max_val = 8'd3;
            2: max_val = 8'd9;
            default: max_val = 8'd255;
         endcase
         sat_mode = 1'($urandom_range(0, 1));
         en       = CH'($urandom);
         up       = CH'($urandom);
         down     = CH'($urandom);
         load     = CH'($urandom) & CH'($urandom) & CH'($urandom);
         load_val = (CH*W)'($urandom);
`ifdef UPDN_COUNTER_STICKY_OVF_EN
         ovf_clr  = CH'($urandom) & CH'($urandom);
`endif
         rst      = ($urandom_range(0, 63) == 0);
         tick();
      end
      rst = 1'b0; idle();
      tick();
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
